// File: rtl/pc_fetch_control_if.sv
// Fetch-control bus between the IF-stage PC controller and the rest of the pipeline.
// The controller connects through the master modport.
// The incrementor, hazard unit and redirect sources connect through the slave modport.
// Optional feature macro: PC_PERF_CNT_EN adds the RedirectCount and StallCount performance counters.
interface pc_fetch_control_if;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] PCResult;
    logic        FetchValid;
    logic        FlushIFID;
    logic        AlignErr;
`ifdef PC_PERF_CNT_EN
    logic [31:0] RedirectCount;
    logic [31:0] StallCount;

    modport master (
        input  PCAddResult, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
        output PCResult, FetchValid, FlushIFID, AlignErr, RedirectCount, StallCount
    );
    modport slave (
        output PCAddResult, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
        input  PCResult, FetchValid, FlushIFID, AlignErr, RedirectCount, StallCount
    );
`else
    modport master (
        input  PCAddResult, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
        output PCResult, FetchValid, FlushIFID, AlignErr
    );
    modport slave (
        output PCAddResult, Stall, BranchTaken, BranchTarget, Jump, JumpTarget,
        input  PCResult, FetchValid, FlushIFID, AlignErr
    );
`endif
endinterface

// File: rtl/pc_fetch_control.sv
// Program-counter register and next-PC selector for the IF stage of the pipelined MIPS core.
// It holds the PC through a boot delay, honours hazard stalls and takes branch/jump redirects.
// It raises a one-cycle IF/ID flush after each redirect.
// A misaligned redirect target vectors the PC to ERR_VECTOR and sets a sticky AlignErr flag.
// Optional feature macro: PC_PERF_CNT_EN adds the redirect and stall-cycle counters.
module pc_fetch_control #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ERR_VECTOR = 32'h0000_0080,
    parameter int unsigned BOOT_DELAY = 2              // legal range 1..15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pc_fetch_control_if.master    bus
);

    // The unused fourth code is named so that the case statement is full.
    // That code behaves exactly as BOOT.
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        HOLD  = 2'b10,
        SPARE = 2'b11
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

    state_t      state, nextState;
    logic [3:0]  bootCnt, nextBootCnt;
    logic [31:0] pcReg, nextPc;
    logic        fetchValidReg, nextFetchValid;
    logic        flushReg, nextFlush;
    logic        alignErrReg, nextAlignErr;

    // Jump has priority over a branch.
    // Only the selected target is checked for alignment.
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        misaligned;

    assign redirect       = bus.Jump | bus.BranchTaken;
    assign redirectTarget = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
    assign misaligned     = redirect && (redirectTarget[1:0] != 2'b00);

    // Next-state, next-PC and registered-output selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        nextState      = state;
        nextBootCnt    = bootCnt;
        nextPc         = pcReg;
        nextFetchValid = 1'b0;
        nextFlush      = 1'b0;
        nextAlignErr   = alignErrReg;

        case (state)
            RUN, HOLD: begin
                if (redirect) begin
                    nextState      = RUN;
                    nextFetchValid = 1'b1;
                    nextFlush      = 1'b1;
                    if (misaligned) begin
                        nextPc       = ERR_VECTOR;
                        nextAlignErr = 1'b1;
                    end else begin
                        nextPc = redirectTarget;
                    end
                end else if (bus.Stall) begin
                    nextState = HOLD;
                end else if (state == HOLD) begin
                    // Leaving HOLD re-presents the held PC as a fresh fetch.
                    nextState      = RUN;
                    nextFetchValid = 1'b1;
                end else begin
                    nextPc         = bus.PCAddResult;
                    nextFetchValid = 1'b1;
                end
            end
            default: begin
                // BOOT and the spare code both land here.
                // Redirect and stall inputs are ignored in this state.
                nextPc = RESET_PC;
                if (bootCnt >= BOOT_LAST) begin
                    nextState      = RUN;
                    nextBootCnt    = 4'd0;
                    nextFetchValid = 1'b1;
                end else begin
                    nextBootCnt = bootCnt + 4'd1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset taking top priority.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state         <= BOOT;
            bootCnt       <= 4'd0;
            pcReg         <= RESET_PC;
            fetchValidReg <= 1'b0;
            flushReg      <= 1'b0;
            alignErrReg   <= 1'b0;
        end else begin
            state         <= nextState;
            bootCnt       <= nextBootCnt;
            pcReg         <= nextPc;
            fetchValidReg <= nextFetchValid;
            flushReg      <= nextFlush;
            alignErrReg   <= nextAlignErr;
        end
    end

    assign bus.PCResult   = pcReg;
    assign bus.FetchValid = fetchValidReg;
    assign bus.FlushIFID  = flushReg;
    assign bus.AlignErr   = alignErrReg;

`ifdef PC_PERF_CNT_EN
    logic        countRedirect;
    logic        countStall;
    logic [31:0] redirectCountReg;
    logic [31:0] stallCountReg;

    // Neither counter can advance in BOOT.
    // Only RUN and HOLD accept redirects, and HOLD is never BOOT.
    assign countRedirect = ((state == RUN) || (state == HOLD)) && redirect;
    assign countStall    = (state == HOLD);

    // Free-running performance counters that wrap modulo 2^32.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            redirectCountReg <= 32'd0;
            stallCountReg    <= 32'd0;
        end else begin
            if (countRedirect) redirectCountReg <= redirectCountReg + 32'd1;
            if (countStall)    stallCountReg    <= stallCountReg + 32'd1;
        end
    end

    assign bus.RedirectCount = redirectCountReg;
    assign bus.StallCount    = stallCountReg;
`endif

endmodule

// File: tb/tb_pc_fetch_control.sv
// Self-checking bench for pc_fetch_control (RESET_PC=0, ERR_VECTOR=0x80, BOOT_DELAY=2).
// A vector table covers boot, stall/hold, redirects and mid-HOLD reset.
// Hand-written sequences cover PC wrap and, with PC_PERF_CNT_EN, the counters.
module tb_pc_fetch_control;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] brT;
        logic        jmp;
        logic [31:0] jT;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
    } exp_t;

    logic Clk;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbQ[$];

    pc_fetch_control_if bus();

    // The PC+4 incrementor that sits beside the controller in the IF stage.
    assign bus.PCAddResult = bus.PCResult + 32'd4;

    pc_fetch_control #(
        .RESET_PC  (32'h0000_0000),
        .ERR_VECTOR(32'h0000_0080),
        .BOOT_DELAY(2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] brT, input logic jmp, input logic [31:0] jT,
                                input logic [31:0] pc, input logic fv, input logic fl,
                                input logic ae);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.brT = brT; v.jmp = jmp; v.jT = jT;
        v.pc = pc; v.fv = fv; v.fl = fl; v.ae = ae;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    // Then compare them one time unit after the edge.
    task automatic applyVec(input vec_t v, input string tag);
        exp_t e;
        Reset            = v.rst;
        bus.Stall        = v.stall;
        bus.BranchTaken  = v.br;
        bus.BranchTarget = v.brT;
        bus.Jump         = v.jmp;
        bus.JumpTarget   = v.jT;
        sbQ.push_back('{v.pc, v.fv, v.fl, v.ae});
        @(posedge Clk);
        #1;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sbQ.pop_front();
            check({tag, " PCResult"},   bus.PCResult,   e.pc);
            check({tag, " FetchValid"}, 32'(bus.FetchValid), 32'(e.fv));
            check({tag, " FlushIFID"},  32'(bus.FlushIFID),  32'(e.fl));
            check({tag, " AlignErr"},   32'(bus.AlignErr),   32'(e.ae));
        end
    endtask

    vec_t vecs[23];

    initial begin
        Reset            = 1'b1;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'h0;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = 32'h0;

        //               rst  stl  br   brT           jmp  jT            pc            fv   fl   ae
        vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,1'b0,1'b0,1'b0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,1'b0,1'b0,1'b0);
        vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,1'b0,1'b0,1'b0);
        // BOOT ignores stall and redirects
        vecs[3]  = mk(1'b0,1'b1,1'b1,32'h400,     1'b1,32'h800,     32'h0000_0000,1'b0,1'b0,1'b0);
        vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,1'b1,1'b0,1'b0);
        vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0004,1'b1,1'b0,1'b0);
        vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0008,1'b1,1'b0,1'b0);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_000C,1'b1,1'b0,1'b0);
        vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0010,1'b1,1'b0,1'b0);
        // three stall cycles then release re-presents 0x10
        vecs[9]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0010,1'b0,1'b0,1'b0);
        vecs[10] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0010,1'b0,1'b0,1'b0);
        vecs[11] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0010,1'b0,1'b0,1'b0);
        vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0010,1'b1,1'b0,1'b0);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0014,1'b1,1'b0,1'b0);
        // branch during stall overrides HOLD
        vecs[14] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0014,1'b0,1'b0,1'b0);
        vecs[15] = mk(1'b0,1'b1,1'b1,32'h400,     1'b0,32'h0,       32'h0000_0400,1'b1,1'b1,1'b0);
        vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0404,1'b1,1'b0,1'b0);
        // jump beats misaligned branch; then misaligned branch; then aligned jump keeps AlignErr
        vecs[17] = mk(1'b0,1'b0,1'b1,32'h402,     1'b1,32'h800,     32'h0000_0800,1'b1,1'b1,1'b0);
        vecs[18] = mk(1'b0,1'b0,1'b1,32'h402,     1'b0,32'h0,       32'h0000_0080,1'b1,1'b1,1'b1);
        vecs[19] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h200,     32'h0000_0200,1'b1,1'b1,1'b1);
        vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0204,1'b1,1'b0,1'b1);
        // reset mid-HOLD with a branch pending
        vecs[21] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0204,1'b0,1'b0,1'b1);
        vecs[22] = mk(1'b1,1'b1,1'b1,32'h400,     1'b0,32'h0,       32'h0000_0000,1'b0,1'b0,1'b0);

        for (int i = 0; i < 23; i++) begin
            applyVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Boot again, jump near the top of memory and fetch across the wrap.
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'h0000_0000,1'b0,1'b0,1'b0), "wrap_boot0");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'h0000_0000,1'b1,1'b0,1'b0), "wrap_boot1");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b1,32'hFFFF_FFF8,  32'hFFFF_FFF8,1'b1,1'b1,1'b0), "wrap_jump");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'hFFFF_FFFC,1'b1,1'b0,1'b0), "wrap_top");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'h0000_0000,1'b1,1'b0,1'b0), "wrap_zero");

        // A second redirect and a three-cycle stall give two redirects and three HOLD cycles.
        applyVec(mk(1'b0,1'b0,1'b1,32'h100,1'b0,32'h0,        32'h0000_0100,1'b1,1'b1,1'b0), "perf_br");
        applyVec(mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,          32'h0000_0100,1'b0,1'b0,1'b0), "perf_stall0");
        applyVec(mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,          32'h0000_0100,1'b0,1'b0,1'b0), "perf_stall1");
        applyVec(mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,          32'h0000_0100,1'b0,1'b0,1'b0), "perf_stall2");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'h0000_0100,1'b1,1'b0,1'b0), "perf_release");
`ifdef PC_PERF_CNT_EN
        check("RedirectCount", bus.RedirectCount, 32'd2);
        check("StallCount",    bus.StallCount,    32'd3);
`endif

        // A misaligned jump target alone vectors to ERR_VECTOR.
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b1,32'h301,        32'h0000_0080,1'b1,1'b1,1'b1), "mis_jump");
        applyVec(mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,          32'h0000_0084,1'b1,1'b0,1'b1), "mis_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
